// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed N-digit 7-segment scan driver
// Shadow/display double buffering keeps a frame from mixing old and new digits.
module seg7_scan_driver #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int HEX_MODE    = 1,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  blank_lz,
  input  logic                  load,
  output logic [7:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PS_W  = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
  localparam logic [PS_W-1:0]  LAST_PS  = PS_W'(REFRESH_DIV - 1);
  localparam logic             INV      = (ACTIVE_LOW != 0);

  logic [PS_W-1:0]       presc;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] shadow_value, disp_value;
  logic [N_DIGITS-1:0]   shadow_dp, disp_dp;
  logic                  shadow_blz, disp_blz;
  logic                  pending;

  logic                  tick, wrap;
  logic [3:0]            cur_nib;
  logic                  cur_dp, cur_blank, all_zero;
  logic [N_DIGITS-1:0]   an_on;
  logic [7:0]            seg_lit;

  assign tick = (presc == LAST_PS);
  assign wrap = tick && (idx == LAST_IDX);

  function automatic logic [6:0] decode(input logic [3:0] n);
    if (HEX_MODE == 0 && n > 4'd9) return 7'h00;
    case (n)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  // Walk from the most significant digit down so all_zero means "this digit and everything above it is zero".
  always_comb begin
    all_zero  = 1'b1;
    cur_nib   = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_on     = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (disp_value[4*i +: 4] == 4'd0);
      if (idx == IDX_W'(i)) begin
        cur_nib   = disp_value[4*i +: 4];
        cur_dp    = disp_dp[i];
        an_on[i]  = 1'b1;
        cur_blank = disp_blz && (i != 0) && all_zero;
      end
    end
    seg_lit = {cur_dp, cur_blank ? 7'h00 : decode(cur_nib)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc        <= '0;
      idx          <= '0;
      shadow_value <= '0;
      shadow_dp    <= '0;
      shadow_blz   <= 1'b0;
      disp_value   <= '0;
      disp_dp      <= '0;
      disp_blz     <= 1'b0;
      pending      <= 1'b0;
      seg          <= {8{INV}};
      an           <= {N_DIGITS{INV}};
      frame_done   <= 1'b0;
    end else begin
      presc      <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= wrap ? '0 : idx + 1'b1;
      frame_done <= wrap;
      seg        <= seg_lit ^ {8{INV}};
      an         <= an_on ^ {N_DIGITS{INV}};

      if (load) begin
        shadow_value <= value;
        shadow_dp    <= dp_in;
        shadow_blz   <= blank_lz;
      end
      // A load on the wrap cycle bypasses the shadow so it appears in the frame starting now.
      if (wrap && load) begin
        disp_value <= value;
        disp_dp    <= dp_in;
        disp_blz   <= blank_lz;
        pending    <= 1'b0;
      end else if (wrap && pending) begin
        disp_value <= shadow_value;
        disp_dp    <= shadow_dp;
        disp_blz   <= shadow_blz;
        pending    <= 1'b0;
      end else if (load) begin
        pending    <= 1'b1;
      end
    end
  end

endmodule
